// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter.
//   state_e : main FSM states (IDLE / ACCESS / RESP)
//   owner_e : which requester currently holds the memory port
//   WAIT_W / STARVE_W : counter widths covering WAIT 0..7 and STARVE_MAX 1..15
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam int unsigned WAIT_W   = 3;
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Arbitration pick logic for the memory port arbiter.
// Data wins over fetch unless fetch has lost STARVE_MAX consecutive
// arbitrations while requesting; the loss counter advances on arb.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   f_req, d_req  : fetch / data requests
//   arb           : strobe, high when the main FSM arbitrates this edge
//   valid         : at least one request present
//   winner        : requester that would be granted this edge
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   f_req,
  input  logic   d_req,
  input  logic   arb,
  output logic   valid,
  output owner_e winner
);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                fetch_wins;

  always_comb begin
    fetch_wins   = f_req && (!d_req || (starve_cnt_q == STARVE_W'(STARVE_MAX)));
    valid        = f_req || d_req;
    winner       = fetch_wins ? OWN_FETCH : OWN_DATA;
    starve_cnt_d = starve_cnt_q;
    if (arb) begin
      if (!f_req || fetch_wins) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_W'(STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported program/data memory between instruction fetch
// and the operand data path. Each access runs WAIT+1 ACCESS cycles followed
// by one RESP cycle carrying the ack; RESP arbitrates again so back-to-back
// accesses need no idle gap. All outputs are registered.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   f_req/f_addr/f_gnt/f_ack      : fetch requester handshake
//   d_req/d_we/d_addr/d_wdata     : data requester request
//   d_gnt/d_ack                   : data requester handshake outputs
//   rdata                         : read data, held until the next read ack
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           : memory macro interface
//   busy                          : access in flight (ACCESS or RESP)
//   owner                         : current owner, 0 fetch / 1 data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned WAIT       = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic                f_gnt_q, f_gnt_d, f_ack_q, f_ack_d;
  logic                d_gnt_q, d_gnt_d, d_ack_q, d_ack_d;

  logic                arb;
  logic                valid;
  owner_e              winner;

  assign arb = (state_q != ST_ACCESS);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .f_req  (f_req),
    .d_req  (d_req),
    .arb    (arb),
    .valid  (valid),
    .winner (winner)
  );

  // mem_we_q doubles as the latched write flag; it is cleared outside ACCESS
  // so the macro never sees a write strobe without mem_en.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    busy_d      = 1'b0;
    f_gnt_d     = 1'b0;
    f_ack_d     = 1'b0;
    d_gnt_d     = 1'b0;
    d_ack_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (valid) begin
          state_d  = ST_ACCESS;
          owner_d  = winner;
          wait_d   = WAIT_W'(WAIT);
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          if (winner == OWN_DATA) begin
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
            d_gnt_d     = 1'b1;
          end else begin
            mem_addr_d  = f_addr;
            mem_wdata_d = '0;
            f_gnt_d     = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        busy_d = 1'b1;
        if (wait_q == '0) begin
          state_d = ST_RESP;
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          if (owner_q == OWN_DATA) begin
            d_ack_d = 1'b1;
          end else begin
            f_ack_d = 1'b1;
          end
        end else begin
          wait_d   = wait_q - WAIT_W'(1);
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      wait_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      f_gnt_q     <= 1'b0;
      f_ack_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      f_gnt_q     <= f_gnt_d;
      f_ack_q     <= f_ack_d;
      d_gnt_q     <= d_gnt_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign f_gnt     = f_gnt_q;
  assign f_ack     = f_ack_q;
  assign d_gnt     = d_gnt_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
